// File: rtl/four_div_two_pkg.sv
// Shared types and display constants for the four_div_two divider and
// the matching seven-segment display logic.
package four_div_two_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Segments a-g in bits 0-6, active-high; dp (bit 7) and bit 8 stay low.
  localparam logic [8:0] SEG_HEX [0:15] = '{
    9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066, 9'h06d, 9'h07d, 9'h007,
    9'h07f, 9'h06f, 9'h077, 9'h07c, 9'h039, 9'h05e, 9'h079, 9'h071
  };

  localparam logic [8:0] SEG_DASH  = 9'h040;
  localparam logic [8:0] SEG_BLANK = 9'h000;

endpackage

// File: rtl/four_div_two_seg7.sv
// Combinational hex-to-seven-segment decoder with a dash override;
// shared with the multiplier display.
module seg7_hex_decoder
  import four_div_two_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dash,
  output logic [8:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else begin
      seg = SEG_HEX[value];
    end
  end

endmodule

// File: rtl/four_div_two.sv
// Sequential restoring divider (DW-bit dividend / VW-bit divisor) driving
// active-low result LEDs and a seven-segment pattern of the quotient.
module four_div_two
  import four_div_two_pkg::*;
#(
  parameter int unsigned DW = 4,
  parameter int unsigned VW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic          div_zero,
  output logic [DW-1:0] q_led_n,
  output logic [VW-1:0] r_led_n,
  output logic [8:0]    seg
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  state_t state, state_nx;

  logic [DW-1:0] dvd_sh;
  logic [VW-1:0] dvs_r;
  logic [VW-1:0] p_rem;
  logic [DW-1:0] q_acc;
  logic [CW-1:0] step;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  logic [VW:0]   t;
  logic          ge;
  logic [VW-1:0] p_rem_nx;
  logic [DW-1:0] q_acc_nx;
  logic          last_step;
  logic          dz;
  logic [3:0]    q_hex;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    t         = {p_rem, dvd_sh[DW-1]};
    ge        = (t >= {1'b0, dvs_r});
    p_rem_nx  = ge ? VW'(t - {1'b0, dvs_r}) : VW'(t);
    q_acc_nx  = (q_acc << 1) | DW'(ge);
    last_step = (step == CW'(DW - 1));
    dz        = (divisor == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = dz ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Results load on the edge that enters DONE and hold through later runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_sh    <= '0;
      dvs_r     <= '0;
      p_rem     <= '0;
      q_acc     <= '0;
      step      <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_sh <= dividend;
            dvs_r  <= divisor;
            p_rem  <= '0;
            q_acc  <= '0;
            step   <= '0;
            if (dz) begin
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_sh <= dvd_sh << 1;
          p_rem  <= p_rem_nx;
          q_acc  <= q_acc_nx;
          step   <= step + 1'b1;
          if (last_step) begin
            quotient  <= q_acc_nx;
            remainder <= p_rem_nx;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    q_led_n         = ~quotient;
    r_led_n         = ~remainder;
    q_hex           = '0;
    q_hex[DW-1:0]   = quotient;
  end

  seg7_hex_decoder u_seg (
    .value (q_hex),
    .dash  (div_zero),
    .seg   (seg)
  );

endmodule

// File: doc/four_div_two.md
Name: four_div_two

Overview:
- Sequential restoring divider: 4-bit dividend ÷ 2-bit divisor, producing a 4-bit quotient and a 2-bit remainder.
- Inverse-direction companion to the team's 2×2 combinational multiplier. It uses the same board outputs:
  - active-low result LEDs;
  - 9-bit seven-segment pattern bus (segments a–g in bits 0–6, active-high, bit 7 dp = 0, bit 8 = 0).
- Takes operands from board switches via a start pulse and signals completion with a one-cycle done pulse.

Parameters:
- DW, 4, dividend/quotient width; the seven-segment map covers 0–15, so DW ≤ 4.
- VW, 2, divisor/remainder width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- dividend  input  DW  numerator, latched when start is accepted
- divisor  input  VW  denominator, latched when start is accepted
- busy  output  1  high while an operation is in progress (RUN)
- done  output  1  one-cycle completion pulse
- div_zero  output  1  sticky flag: last operation had divisor = 0
- q_led_n  output  DW  quotient LEDs, active-low (= ~quotient)
- r_led_n  output  VW  remainder LEDs, active-low (= ~remainder)
- seg  output  9  seven-segment pattern of the quotient

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset values: busy=0, done=0, div_zero=0, quotient=0, remainder=0, so q_led_n=all 1s, r_led_n=all 1s, seg=9'h03f.
  - rst asserted mid-RUN aborts the operation: no done pulse, and the stored results are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches dividend and divisor.
  - If divisor≠0: go to RUN, clear the step counter, clear the partial remainder.
  - If divisor=0: go straight to DONE.
- RUN:
  - busy=1. Runs exactly DW steps, MSB first.
  - Each step: t = {partial_rem[VW-1:0], next dividend bit}, width VW+1.
    - If t ≥ divisor: partial_rem = t − divisor and quotient bit = 1.
    - Otherwise: partial_rem = t and quotient bit = 0.
  - After step DW−1, go to DONE.
- DONE (one cycle):
  - done=1, busy=0. The result registers update on entry to DONE.
  - Normal operation: quotient and remainder take the computed values; div_zero=0.
  - Divide-by-zero: quotient=all 1s, remainder=0, div_zero=1.
  - Next state is always IDLE.
- Latency: start accepted in cycle N gives done in cycle N+DW+1 (N+5 at default), or N+1 for divide-by-zero.
- Start handling:
  - start in RUN or DONE is ignored: no queuing, operands are not re-latched.
  - start held high re-triggers on the first IDLE cycle, so the earliest back-to-back accept is cycle N+DW+2.
- Result hold: results, LEDs and seg hold their values until the next DONE or rst. They are not disturbed during a subsequent RUN.
- LED outputs: q_led_n = ~quotient and r_led_n = ~remainder, taken directly from registers.
- seg output:
  - seg is a combinational decode of the registered quotient.
  - Patterns 0–15: 3f 06 5b 4f 66 6d 7d 07 7f 6f 77 7c 39 5e 79 71.
  - If div_zero=1, seg = 9'h040 (dash), overriding the quotient pattern.
- Invariants: remainder < divisor whenever div_zero=0, and quotient·divisor + remainder = dividend.

Decomposition:
- Shared package four_div_two_pkg holds:
  - FSM state enum (IDLE/RUN/DONE);
  - SEG_HEX[0:15] pattern constants;
  - SEG_DASH=9'h040 and SEG_BLANK=9'h000.
- One sub-module: seg7_hex_decoder, combinational, 4-bit value + dash flag → 9-bit seg. It is reusable by the multiplier display.
- Divider datapath and FSM stay in four_div_two.

Test Plan:
- Reset: rst high 2 cycles → busy=0, done=0, div_zero=0, q_led_n=4'hF, r_led_n=2'b11, seg=9'h03f.
- Basic divide: 13/3, start in cycle N → busy high cycles N+1..N+4; done in N+5; quotient=4, remainder=1; q_led_n=4'hB, r_led_n=2'b10, seg=9'h066.
- Boundary: 15/1 → quotient 15, remainder 0, seg=9'h071. Then 0/3 → quotient 0, remainder 0, seg=9'h03f. Then 2/3 → quotient 0, remainder 2.
- Divide-by-zero: 7/0 → done in N+1; div_zero=1, q_led_n=4'h0, r_led_n=2'b11, seg=9'h040. A following 9/2 → div_zero clears, quotient 4, remainder 1.
- Ignored start: start 13/3, then pulse start with 6/2 during RUN → result stays 4 r1, exactly one done pulse. start held high continuously → successive accepts every DW+2 cycles.
- Reset mid-op: rst in cycle N+2 of a 13/3 operation → no done pulse, outputs return to reset values, next 10/3 gives quotient 3, remainder 1.
